morse_guess_checker: RTL and testbench
======================================

// Module: morse_guess_checker
// PURPOSE
//  Parametrised player-2 guess engine for the morse game, successor to the fixed 5-symbol checker.
//  Latches player 1's code at game start and scores dot/line pulses from morse_decoder symbol by symbol.
//  Supports any code length and a limited number of attempts, and ends in a held WIN or LOSE result.
//  Sits between morse_decoder (ld_dot/ld_line) and the display/score logic.
// PARAMETERS
//  MAX_SYMBOLS   5  max symbols per code; each symbol is 2 bits (00 none, 01 dot, 11 line)
//  MAX_ATTEMPTS  3  wrong guesses allowed before LOSE (>=1)
// PORTS
//  clock          in   1      system clock; all logic on posedge
//  reset          in   1      synchronous, active-high reset
//  start          in   1      1-cycle pulse: latch p1_value, begin new game
//  ld_dot         in   1      1-cycle pulse from morse_decoder: player 2 entered a dot
//  ld_line        in   1      1-cycle pulse from morse_decoder: player 2 entered a line
//  done_input     in   1      player 2 declares the guess finished
//  p1_value       in   2*MAX_SYMBOLS  player 1 code, symbol 0 in the MSBs
//  q              out  2*MAX_SYMBOLS  player 2 entry, left-aligned like p1_value, unused symbols 00
//  correct        out  1      1-cycle pulse: last symbol matched
//  wrong          out  1      1-cycle pulse: a miss was charged
//  complete       out  1      high while in WIN
//  failed         out  1      high while in LOSE
//  sym_count      out  $clog2(MAX_SYMBOLS+1)  symbols correctly entered in the current attempt
//  attempts_left  out  $clog2(MAX_ATTEMPTS+1) remaining attempts
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous and active-high.
//  - Reset values: state IDLE, q=0, correct=0, wrong=0, complete=0, failed=0, sym_count=0, attempts_left=0.
//  - FSM states: IDLE, GUESS, WIN, LOSE. All outputs are registered.
//  - code_len is the number of leading non-00 symbols in the latched code. The first 00 symbol ends the code; later symbols are ignored.
//  - start is accepted in IDLE, WIN and LOSE, and ignored in GUESS. On acceptance:
//    - latch p1_value into p1_copy and clear q and sym_count;
//    - set attempts_left=MAX_ATTEMPTS;
//    - go to GUESS, or go directly to WIN if code_len==0.
//  - p1_value changes after start have no effect until the next start.
//  - In GUESS, an input is valid when exactly one of ld_dot/ld_line is high. Both high together is ignored (no pulse, no charge).
//  - Valid input whose symbol equals expected symbol[sym_count]:
//    - write the symbol into q at symbol slot sym_count;
//    - sym_count+1; correct=1 on the next cycle;
//    - if sym_count+1==code_len, go to WIN in the same update.
//  - Valid input that mismatches: charge a miss.
//  - done_input in GUESS with sym_count<code_len: charge a miss. done_input on the same cycle as a valid input is ignored; the symbol is processed.
//  - Charging a miss: wrong=1 on the next cycle, q=0, sym_count=0, attempts_left-1. If the result is 0, go to LOSE.
//  - Latency: correct/wrong/complete/failed assert exactly 1 cycle after the triggering input cycle.
//  - In WIN and LOSE all symbol and done inputs are ignored. q and sym_count hold their values; attempts_left holds (0 in LOSE).
//  - correct and wrong are never high together, and each is high for at most 1 cycle per event.
//  - reset mid-game returns to IDLE on the next edge, regardless of other inputs.
//  - Invariant: complete implies q == p1_copy with bits below code_len cleared to 00.
// TESTING
//  Params MAX_SYMBOLS=5, MAX_ATTEMPTS=3; code 10'b01_11_01_00_00 (dot line dot):
//  1. start, then dot, line, dot -> correct pulses x3, q=10'b01_11_01_00_00, sym_count=3, complete=1 one cycle after the last dot.
//  2. start, dot, dot -> 2nd dot: wrong=1, q=0, sym_count=0, attempts_left=2; then dot,line,dot -> complete=1.
//  3. start, then line x3 (each a miss) -> attempts_left 2,1,0, failed=1 after the third; further ld_dot changes nothing.
//  4. start, dot, done_input -> wrong=1, attempts_left=2. Also: ld_dot&ld_line in the same cycle -> no pulse, no state change.
//  5. code 10'b0 with start -> complete=1 next cycle, sym_count=0. start in GUESS is ignored; p1_value change mid-game is ignored.
//  6. reset asserted mid-GUESS with sym_count=2 -> next cycle: all outputs 0, IDLE; start then begins a fresh game.

Source files
------------

// File: rtl/morse_guess_checker.sv
// Player-2 guess engine for the morse game: latches player 1's code on start,
// scores dot/line entries symbol by symbol and ends in a held WIN or LOSE.
module morse_guess_checker #(
  parameter int MAX_SYMBOLS  = 5,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                ld_dot,
  input  logic                                ld_line,
  input  logic                                done_input,
  input  logic [2*MAX_SYMBOLS-1:0]            p1_value,
  output logic [2*MAX_SYMBOLS-1:0]            q,
  output logic                                correct,
  output logic                                wrong,
  output logic                                complete,
  output logic                                failed,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]    sym_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left
);

  localparam int W  = 2 * MAX_SYMBOLS;
  localparam int CW = $clog2(MAX_SYMBOLS + 1);
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUESS,
    S_WIN,
    S_LOSE
  } state_t;

  // Number of leading non-00 symbols; the first 00 terminates the code.
  function automatic logic [CW-1:0] f_code_len(input logic [W-1:0] v);
    logic          stop;
    logic [CW-1:0] len;
    stop = 1'b0;
    len  = '0;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (!stop) begin
        if (v[W-1-2*i -: 2] == 2'b00) stop = 1'b1;
        else                          len  = len + 1'b1;
      end
    end
    return len;
  endfunction

  state_t        r_state,     w_state_nx;
  logic [W-1:0]  r_p1_copy,   w_p1_nx;
  logic [W-1:0]  r_q,         w_q_nx;
  logic [CW-1:0] r_sym_count, w_sym_nx;
  logic [AW-1:0] r_attempts,  w_att_nx;
  logic          r_correct,   w_correct_nx;
  logic          r_wrong,     w_wrong_nx;
  logic          r_complete;
  logic          r_failed;

  logic          w_valid;
  logic [1:0]    w_sym;
  logic [1:0]    w_expected;
  logic [CW-1:0] w_code_len;
  logic [CW-1:0] w_sym_inc;
  logic [AW-1:0] w_att_dec;
  logic          w_miss;

  assign w_valid    = ld_dot ^ ld_line;
  assign w_sym      = ld_dot ? 2'b01 : 2'b11;
  assign w_code_len = f_code_len(r_p1_copy);
  assign w_sym_inc  = r_sym_count + 1'b1;
  assign w_att_dec  = r_attempts - 1'b1;

  always_comb begin
    w_expected = 2'b00;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (r_sym_count == CW'(i)) w_expected = r_p1_copy[W-1-2*i -: 2];
    end
  end

  always_comb begin
    // NOTE: every next value defaults to "hold" first, so no branch can infer a latch.
    w_state_nx   = r_state;
    w_p1_nx      = r_p1_copy;
    w_q_nx       = r_q;
    w_sym_nx     = r_sym_count;
    w_att_nx     = r_attempts;
    w_correct_nx = 1'b0;
    w_wrong_nx   = 1'b0;
    w_miss       = 1'b0;

    case (r_state)
      S_GUESS: begin
        if (w_valid) begin
          if (w_sym == w_expected) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
              if (r_sym_count == CW'(i)) w_q_nx[W-1-2*i -: 2] = w_sym;
            end
            w_sym_nx     = w_sym_inc;
            w_correct_nx = 1'b1;
            if (w_sym_inc == w_code_len) w_state_nx = S_WIN;
          end else begin
            w_miss = 1'b1;
          end
        end else if (done_input && (r_sym_count < w_code_len)) begin
          w_miss = 1'b1;
        end

        if (w_miss) begin
          w_q_nx     = '0;
          w_sym_nx   = '0;
          w_att_nx   = w_att_dec;
          w_wrong_nx = 1'b1;
          if (w_att_dec == '0) w_state_nx = S_LOSE;
        end
      end

      default: begin
        // IDLE, WIN and LOSE only react to start.
        if (start) begin
          w_p1_nx    = p1_value;
          w_q_nx     = '0;
          w_sym_nx   = '0;
          w_att_nx   = AW'(MAX_ATTEMPTS);
          w_state_nx = (f_code_len(p1_value) == '0) ? S_WIN : S_GUESS;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_p1_copy   <= '0;
      r_q         <= '0;
      r_sym_count <= '0;
      r_attempts  <= '0;
      r_correct   <= 1'b0;
      r_wrong     <= 1'b0;
      r_complete  <= 1'b0;
      r_failed    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nx;
      r_p1_copy   <= w_p1_nx;
      r_q         <= w_q_nx;
      r_sym_count <= w_sym_nx;
      r_attempts  <= w_att_nx;
      r_correct   <= w_correct_nx;
      r_wrong     <= w_wrong_nx;
      r_complete  <= (w_state_nx == S_WIN);
      r_failed    <= (w_state_nx == S_LOSE);
    end
  end

  assign q             = r_q;
  assign correct       = r_correct;
  assign wrong         = r_wrong;
  assign complete      = r_complete;
  assign failed        = r_failed;
  assign sym_count     = r_sym_count;
  assign attempts_left = r_attempts;

endmodule

// File: tb/tb_morse_guess_checker.sv
// Directed, table-driven bench for morse_guess_checker (MAX_SYMBOLS=5, MAX_ATTEMPTS=3).
module tb_morse_guess_checker;

  logic       clock = 1'b0;
  logic       reset, start, ld_dot, ld_line, done_input;
  logic [9:0] p1_value;
  logic [9:0] q;
  logic       correct, wrong, complete, failed;
  logic [2:0] sym_count;
  logic [1:0] attempts_left;

  int total = 0;
  int bad   = 0;

  morse_guess_checker #(.MAX_SYMBOLS(5), .MAX_ATTEMPTS(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .ld_dot        (ld_dot),
    .ld_line       (ld_line),
    .done_input    (done_input),
    .p1_value      (p1_value),
    .q             (q),
    .correct       (correct),
    .wrong         (wrong),
    .complete      (complete),
    .failed        (failed),
    .sym_count     (sym_count),
    .attempts_left (attempts_left)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, st, d, l, dn;
    logic [9:0] p1;
    logic [9:0] q;
    logic       cor, wr, cmp, fl;
    logic [2:0] sc;
    logic [1:0] al;
  } vec_t;

  vec_t vq[$];

  localparam logic [9:0] C   = 10'b01_11_01_00_00;  // dot line dot
  localparam logic [9:0] ALT = 10'b11_00_00_00_00;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic d, input logic l,
                       input logic dn, input logic [9:0] p1);
    reset = rst; start = st; ld_dot = d; ld_line = l; done_input = dn; p1_value = p1;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [9:0] eq, input logic ecor, input logic ewr,
                           input logic ecmp, input logic efl, input logic [2:0] esc, input logic [1:0] eal);
    check("q",             idx, 32'(q),             32'(eq));
    check("correct",       idx, 32'(correct),       32'(ecor));
    check("wrong",         idx, 32'(wrong),         32'(ewr));
    check("complete",      idx, 32'(complete),      32'(ecmp));
    check("failed",        idx, 32'(failed),        32'(efl));
    check("sym_count",     idx, 32'(sym_count),     32'(esc));
    check("attempts_left", idx, 32'(attempts_left), 32'(eal));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_dot = 1'b0; ld_line = 1'b0; done_input = 1'b0; p1_value = '0;

    //          rst st d  l  dn p1    | q       cor wr cmp fl sc al
    vq.push_back('{1, 0, 0, 0, 0, 10'h0, 10'h000, 0, 0, 0, 0, 0, 0});  // reset state
    // correct guess dot line dot
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h100, 1, 0, 0, 0, 1, 3});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h1C0, 1, 0, 0, 0, 2, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h1D0, 1, 0, 1, 0, 3, 3});
    vq.push_back('{0, 0, 1, 0, 1, C,     10'h1D0, 0, 0, 1, 0, 3, 3});  // WIN ignores inputs
    // one miss, then success
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h100, 1, 0, 0, 0, 1, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h000, 0, 1, 0, 0, 0, 2});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h100, 1, 0, 0, 0, 1, 2});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h1C0, 1, 0, 0, 0, 2, 2});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h1D0, 1, 0, 1, 0, 3, 2});
    // three misses -> LOSE
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h000, 0, 1, 0, 0, 0, 2});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h000, 0, 1, 0, 0, 0, 1});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h000, 0, 1, 0, 1, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h000, 0, 0, 0, 1, 0, 0});  // LOSE ignores inputs
    // done_input miss, both-high ignored, done with valid symbol
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h100, 1, 0, 0, 0, 1, 3});
    vq.push_back('{0, 0, 0, 0, 1, C,     10'h000, 0, 1, 0, 0, 0, 2});
    vq.push_back('{0, 0, 1, 1, 0, C,     10'h000, 0, 0, 0, 0, 0, 2});
    vq.push_back('{0, 0, 1, 0, 1, C,     10'h100, 1, 0, 0, 0, 1, 2});
    vq.push_back('{0, 0, 0, 1, 0, C,     10'h1C0, 1, 0, 0, 0, 2, 2});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h1D0, 1, 0, 1, 0, 3, 2});
    // empty code wins immediately
    vq.push_back('{0, 1, 0, 0, 0, 10'h0, 10'h000, 0, 0, 1, 0, 0, 3});
    vq.push_back('{0, 0, 0, 0, 0, 10'h0, 10'h000, 0, 0, 1, 0, 0, 3});
    // start and p1_value changes during GUESS are ignored
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 1, 0, 0, 0, ALT,   10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 1, 0, 0, ALT,   10'h100, 1, 0, 0, 0, 1, 3});
    vq.push_back('{0, 0, 0, 1, 0, ALT,   10'h1C0, 1, 0, 0, 0, 2, 3});
    // reset mid-GUESS with sym_count=2 wins over a symbol input
    vq.push_back('{1, 0, 1, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 0});  // IDLE ignores symbols
    vq.push_back('{0, 1, 0, 0, 0, C,     10'h000, 0, 0, 0, 0, 0, 3});
    vq.push_back('{0, 0, 1, 0, 0, C,     10'h100, 1, 0, 0, 0, 1, 3});

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].st, vq[i].d, vq[i].l, vq[i].dn, vq[i].p1);
      check_all(i, vq[i].q, vq[i].cor, vq[i].wr, vq[i].cmp, vq[i].fl, vq[i].sc, vq[i].al);
    end

    // Full-length code: line line dot dot line
    drive(1, 0, 0, 0, 0, 10'h0);
    drive(0, 1, 0, 0, 0, 10'b11_11_01_01_11);
    drive(0, 0, 0, 1, 0, 10'h0);
    drive(0, 0, 0, 1, 0, 10'h0);
    drive(0, 0, 1, 0, 0, 10'h0);
    drive(0, 0, 1, 0, 0, 10'h0);
    check_all(100, 10'b11_11_01_01_00, 1, 0, 0, 0, 4, 3);
    drive(0, 0, 0, 1, 0, 10'h0);
    check_all(101, 10'b11_11_01_01_11, 1, 0, 1, 0, 5, 3);
    drive(0, 0, 0, 0, 1, 10'h0);
    check_all(102, 10'b11_11_01_01_11, 0, 0, 1, 0, 5, 3);

    // Symbols after the first 00 are not part of the code
    drive(0, 1, 0, 0, 0, 10'b01_00_11_11_11);
    check_all(103, 10'h000, 0, 0, 0, 0, 0, 3);
    drive(0, 0, 1, 0, 0, 10'h0);
    check_all(104, 10'b01_00_00_00_00, 1, 0, 1, 0, 1, 3);
    drive(0, 0, 0, 0, 0, 10'h0);
    check_all(105, 10'b01_00_00_00_00, 0, 0, 1, 0, 1, 3);

    // Restart from WIN, miss then pulses last exactly one cycle
    drive(0, 1, 0, 0, 0, C);
    drive(0, 0, 0, 1, 0, C);
    check_all(106, 10'h000, 0, 1, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, C);
    check_all(107, 10'h000, 0, 0, 0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
